hamming_decoder_4bit: RTL and testbench
=======================================

Name: hamming_decoder_4bit

Overview:
Downstream consumer of the team's serial-in Hamming(7,4) encoder. It takes one 7-bit codeword per transaction, scans it bit-serially to build the 3-bit syndrome, and corrects any single-bit error. It then presents the 4-bit data word with a one-cycle done pulse, error/syndrome status and a saturating error counter.

Parameters:
ERR_CNT_W, 8, width of the saturating error counter err_cnt (>=1)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
cw_valid  input  1  codeword strobe; sampled only while ready=1
cw  input  7  codeword: cw[6:3]=d3..d0, cw[2]=p2, cw[1]=p1, cw[0]=p0
ready  output  1  high in IDLE only (combinational from state)
done  output  1  one-cycle pulse in DONE; dout/err/syn valid from this cycle
dout  output  4  decoded data d3..d0, registered, held until next CORR
err  output  1  syndrome nonzero for last codeword, registered, held
syn  output  3  syndrome {s2,s1,s0} of last codeword, registered, held
err_cnt  output  ERR_CNT_W  count of codewords with err=1, saturating

Behaviour:
- Parity definition (matches encoder): p0=d0^d1^d2, p1=d0^d2^d3, p2=d1^d2^d3.
- H columns by bit index: 0:001, 1:010, 2:100, 3:011, 4:101, 5:111, 6:110.
- States: IDLE, SCAN, CORR, DONE.
- IDLE: ready=1. On cw_valid=1: cw captured into cw_r, bit counter idx=0, syndrome register=0, go to SCAN. Without cw_valid, stay in IDLE.
- SCAN: 7 cycles, idx 0..6. Each cycle, if cw_r[idx]=1, syndrome ^= H column(idx). idx increments. At idx=6, go to CORR. cw input is ignored during this state.
- CORR: 1 cycle.
  - syn <= syndrome; err <= (syndrome!=0).
  - Syndrome decodes to flip index (001->0, 010->1, 100->2, 011->3, 101->4, 111->5, 110->6).
  - dout <= cw_r[6:3] with the flipped bit inverted. A parity-bit error leaves the data unchanged.
  - If syndrome!=0 and err_cnt!=all-ones, err_cnt increments.
  - Go to DONE.
- DONE: done=1 for exactly this cycle, then IDLE.
- Latency: cw_valid sampled at edge T0 -> done high during cycle T0+9. Ready returns at T0+10.
- Throughput: 1 codeword per 10 cycles minimum.
- cw_valid while ready=0: ignored, not queued.
- Back-to-back: cw_valid held high in the IDLE cycle after DONE starts the next transaction.
- Reset, in any state including mid-SCAN: next state IDLE; cw_r, idx, syndrome, dout, err, syn, err_cnt all cleared to 0. done=0 and ready=1 after reset. An interrupted codeword produces no done.
- Double-bit errors are not detected as such; the syndrome is applied as a single-bit correction, per the (7,4) code.

Optional Feature:
HAMMING_DEC_CORRECT_EN
- Defined: CORR inverts the erroneous data bit as described.
- Undefined: detect-only. dout <= cw_r[6:3] raw. err, syn and err_cnt behave identically; the correction logic is not synthesized.

Test Plan:
- Reset, then cw=7'h58 (d=1011, parity 000) with cw_valid -> done 9 cycles later; dout=4'b1011, err=0, syn=000, err_cnt=0.
- cw=7'h78 (bit5/d2 flipped), correction enabled -> dout=4'b1011, err=1, syn=111, err_cnt=1. Same stimulus with HAMMING_DEC_CORRECT_EN undefined -> dout=4'b1111, err=1, syn=111.
- cw=7'h5A (bit1/p1 flipped) -> dout=4'b1011, err=1, syn=010. cw=7'h00 -> dout=0000, err=0.
- Start 7'h78, then pulse cw_valid with 7'h00 during SCAN -> second codeword ignored; exactly one done, with dout=1011.
- Start a codeword, assert rst at SCAN idx=3 -> no done pulse; all outputs 0, ready=1. A new codeword then decodes normally.
- ERR_CNT_W=2, five back-to-back error codewords -> err_cnt reads 1,2,3,3,3 at successive done pulses.

Source files
------------

// File: rtl/hamming_decoder_4bit.sv
// Bit-serial Hamming(7,4) decoder: scans a captured codeword into a 3-bit syndrome, then corrects and reports.
// Optional: define HAMMING_DEC_CORRECT_EN to invert the erroneous data bit; otherwise detect-only.
module hamming_decoder_4bit #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cw_valid,
  input  logic [6:0]           cw,
  output logic                 ready,
  output logic                 done,
  output logic [3:0]           dout,
  output logic                 err,
  output logic [2:0]           syn,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, SCAN, CORR, DONE} state_t;

  state_t     state;
  logic [6:0] cw_r;
  logic [2:0] idx;
  logic [2:0] syn_acc;
  logic [3:0] data_fix;

  // Parity-check matrix column for each codeword bit position.
  function automatic logic [2:0] h_col(input logic [2:0] i);
    case (i)
      3'd0:    h_col = 3'b001;
      3'd1:    h_col = 3'b010;
      3'd2:    h_col = 3'b100;
      3'd3:    h_col = 3'b011;
      3'd4:    h_col = 3'b101;
      3'd5:    h_col = 3'b111;
      3'd6:    h_col = 3'b110;
      default: h_col = 3'b000;
    endcase
  endfunction

  assign ready = (state == IDLE);

`ifdef HAMMING_DEC_CORRECT_EN
  // Only syndromes pointing at data bits (indices 3..6) change dout.
  always_comb begin
    data_fix = cw_r[6:3];
    case (syn_acc)
      3'b011:  data_fix[0] = ~cw_r[3];
      3'b101:  data_fix[1] = ~cw_r[4];
      3'b111:  data_fix[2] = ~cw_r[5];
      3'b110:  data_fix[3] = ~cw_r[6];
      default: data_fix = cw_r[6:3];
    endcase
  end
`else
  assign data_fix = cw_r[6:3];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cw_r    <= '0;
      idx     <= '0;
      syn_acc <= '0;
      done    <= 1'b0;
      dout    <= '0;
      err     <= 1'b0;
      syn     <= '0;
      err_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cw_valid) begin
            cw_r    <= cw;
            idx     <= '0;
            syn_acc <= '0;
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (cw_r[idx]) begin
            syn_acc <= syn_acc ^ h_col(idx);
          end
          idx <= idx + 3'd1;
          if (idx == 3'd6) begin
            state <= CORR;
          end
        end
        CORR: begin
          syn  <= syn_acc;
          err  <= (syn_acc != 3'b000);
          dout <= data_fix;
          if ((syn_acc != 3'b000) && (err_cnt != {ERR_CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
          end
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_decoder_4bit.sv
// Bench for hamming_decoder_4bit: directed vectors, random codewords vs a parity-recompute model, and a 2-bit counter instance.
module tb_hamming_decoder_4bit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cw_valid = 1'b0;
  logic [6:0] cw = '0;
  logic       ready, done, err;
  logic [3:0] dout;
  logic [2:0] syn;
  logic [7:0] err_cnt;

  logic       cw_valid2 = 1'b0;
  logic [6:0] cw2 = '0;
  logic       ready2, done2, err2;
  logic [3:0] dout2;
  logic [2:0] syn2;
  logic [1:0] err_cnt2;

  int checks = 0;
  int fails = 0;
  int model_cnt = 0;

  always #5 clk = ~clk;

  hamming_decoder_4bit #(.ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cw_valid(cw_valid), .cw(cw), .ready(ready), .done(done),
    .dout(dout), .err(err), .syn(syn), .err_cnt(err_cnt)
  );

  hamming_decoder_4bit #(.ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .cw_valid(cw_valid2), .cw(cw2), .ready(ready2), .done(done2),
    .dout(dout2), .err(err2), .syn(syn2), .err_cnt(err_cnt2)
  );

  // Model: syndrome = received parity XOR parity recomputed from received data.
  function automatic logic [2:0] ref_syn(input logic [6:0] c);
    logic d0, d1, d2, d3;
    d0 = c[3]; d1 = c[4]; d2 = c[5]; d3 = c[6];
    ref_syn = {c[2] ^ (d1 ^ d2 ^ d3), c[1] ^ (d0 ^ d2 ^ d3), c[0] ^ (d0 ^ d1 ^ d2)};
  endfunction

  // Model: find the single bit flip that makes the word a valid codeword.
  function automatic logic [3:0] ref_dout(input logic [6:0] c);
    logic [6:0] t;
    ref_dout = c[6:3];
`ifdef HAMMING_DEC_CORRECT_EN
    if (ref_syn(c) != 3'b000) begin
      for (int i = 0; i < 7; i++) begin
        t = c;
        t[i] = ~t[i];
        if (ref_syn(t) == 3'b000) ref_dout = t[6:3];
      end
    end
`endif
  endfunction

  function automatic logic [6:0] encode(input logic [3:0] d);
    encode = {d, d[1] ^ d[2] ^ d[3], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[2]};
  endfunction

  // Wait for ready, present one codeword, return edges to done counting the capture edge as 1 (-1 on timeout).
  task automatic send(input logic [6:0] c, output int cyc);
    int w;
    w = 0;
    while (!ready && w < 20) begin @(posedge clk); #1; w++; end
    cw_valid = 1'b1;
    cw = c;
    @(posedge clk); #1;
    cw_valid = 1'b0;
    cw = $urandom_range(0, 127);
    cyc = 1;
    while (!done && cyc < 20) begin @(posedge clk); #1; cyc++; end
    if (!done) cyc = -1;
  endtask

  task automatic model_step(input logic [6:0] c);
    if (ref_syn(c) != 3'b000 && model_cnt < 255) model_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({ready, done, dout, err, syn, err_cnt} !== {1'b1, 1'b0, 4'h0, 1'b0, 3'b000, 8'h00}) begin
      fails++;
      $display("FAIL reset_state: got ready=%b done=%b dout=%h err=%b syn=%b cnt=%0d, want 1 0 0 0 000 0",
               ready, done, dout, err, syn, err_cnt);
    end
  endtask

  task automatic test_directed();
    logic [6:0] vec [4];
    int cyc;
    vec[0] = 7'h58; vec[1] = 7'h78; vec[2] = 7'h5A; vec[3] = 7'h00;
    for (int i = 0; i < 4; i++) begin
      send(vec[i], cyc);
      model_step(vec[i]);
      checks++;
      if (cyc !== 9) begin
        fails++;
        $display("FAIL dir_latency[%0d]: done after %0d edges, want 9", i, cyc);
      end
      checks++;
      if ({dout, err, syn, err_cnt} !== {ref_dout(vec[i]), ref_syn(vec[i]) != 3'b000, ref_syn(vec[i]), 8'(model_cnt)}) begin
        fails++;
        $display("FAIL dir_outputs[%0d] cw=%h: got dout=%b err=%b syn=%b cnt=%0d, want dout=%b err=%b syn=%b cnt=%0d",
                 i, vec[i], dout, err, syn, err_cnt, ref_dout(vec[i]), ref_syn(vec[i]) != 3'b000,
                 ref_syn(vec[i]), model_cnt);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || ready !== 1'b1) begin
        fails++;
        $display("FAIL dir_pulse[%0d]: done=%b ready=%b after DONE, want 0 1", i, done, ready);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] c;
    int nflip, cyc;
    for (int n = 0; n < 24; n++) begin
      c = encode(4'($urandom_range(0, 15)));
      nflip = $urandom_range(0, 2);
      for (int f = 0; f < nflip; f++) c[$urandom_range(0, 6)] ^= 1'b1;
      send(c, cyc);
      model_step(c);
      checks++;
      if (cyc !== 9 || dout !== ref_dout(c) || syn !== ref_syn(c) || err !== (ref_syn(c) != 3'b000)
          || err_cnt !== 8'(model_cnt)) begin
        fails++;
        $display("FAIL random[%0d] cw=%h: got cyc=%0d dout=%b err=%b syn=%b cnt=%0d, want cyc=9 dout=%b syn=%b cnt=%0d",
                 n, c, cyc, dout, err, syn, err_cnt, ref_dout(c), ref_syn(c), model_cnt);
      end
    end
  endtask

  task automatic test_ignore_during_scan();
    int ndone;
    while (!ready) begin @(posedge clk); #1; end
    cw_valid = 1'b1; cw = 7'h78;
    @(posedge clk); #1;
    cw_valid = 1'b0;
    @(posedge clk); #1; @(posedge clk); #1;
    cw_valid = 1'b1; cw = 7'h00;
    @(posedge clk); #1;
    cw_valid = 1'b0;
    model_step(7'h78);
    ndone = 0;
    for (int k = 0; k < 25; k++) begin
      if (done) begin
        ndone++;
        checks++;
        if (dout !== ref_dout(7'h78) || syn !== 3'b111) begin
          fails++;
          $display("FAIL ignore_dout: got dout=%b syn=%b, want dout=%b syn=111", dout, syn, ref_dout(7'h78));
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (ndone !== 1) begin
      fails++;
      $display("FAIL ignore_count: got %0d done pulses, want 1", ndone);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] vec [3];
    int last, t, w;
    vec[0] = 7'h5A; vec[1] = 7'h58; vec[2] = 7'h78;
    while (!ready) begin @(posedge clk); #1; end
    cw_valid = 1'b1; cw = vec[0];
    t = 0; last = 0;
    for (int i = 0; i < 3; i++) begin
      w = 0;
      while (!done && w < 20) begin @(posedge clk); #1; t++; w++; end
      model_step(vec[i]);
      checks++;
      if (!done || dout !== ref_dout(vec[i]) || syn !== ref_syn(vec[i]) || (i > 0 && t - last !== 10)) begin
        fails++;
        $display("FAIL b2b[%0d]: got done=%b dout=%b syn=%b spacing=%0d, want 1 %b %b 10",
                 i, done, dout, syn, t - last, ref_dout(vec[i]), ref_syn(vec[i]));
      end
      last = t;
      if (i < 2) cw = vec[i + 1];
      else cw_valid = 1'b0;
      @(posedge clk); #1; t++;
    end
    checks++;
    if (err_cnt !== 8'(model_cnt)) begin
      fails++;
      $display("FAIL b2b_cnt: got %0d, want %0d", err_cnt, model_cnt);
    end
  endtask

  task automatic test_reset_mid_scan();
    int ndone, cyc;
    while (!ready) begin @(posedge clk); #1; end
    cw_valid = 1'b1; cw = 7'h78;
    @(posedge clk); #1;
    cw_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_cnt = 0;
    checks++;
    if ({ready, done, dout, err, syn, err_cnt} !== {1'b1, 1'b0, 4'h0, 1'b0, 3'b000, 8'h00}) begin
      fails++;
      $display("FAIL midscan_reset: got ready=%b done=%b dout=%h err=%b syn=%b cnt=%0d, want 1 0 0 0 000 0",
               ready, done, dout, err, syn, err_cnt);
    end
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    checks++;
    if (ndone !== 0) begin
      fails++;
      $display("FAIL midscan_nodone: got %0d done pulses, want 0", ndone);
    end
    send(7'h58, cyc);
    checks++;
    if (cyc !== 9 || dout !== 4'b1011 || err !== 1'b0 || err_cnt !== 8'h00) begin
      fails++;
      $display("FAIL midscan_recover: got cyc=%0d dout=%b err=%b cnt=%0d, want 9 1011 0 0", cyc, dout, err, err_cnt);
    end
  endtask

  task automatic test_saturation();
    int w, exp;
    logic [6:0] c;
    exp = 0;
    while (!ready2) begin @(posedge clk); #1; end
    cw_valid2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      c = encode(4'($urandom_range(0, 15)));
      c[$urandom_range(0, 6)] ^= 1'b1;
      cw2 = c;
      @(posedge clk); #1;
      w = 1;
      while (!done2 && w < 20) begin @(posedge clk); #1; w++; end
      exp = (exp < 3) ? exp + 1 : 3;
      checks++;
      if (!done2 || err_cnt2 !== 2'(exp) || err2 !== 1'b1) begin
        fails++;
        $display("FAIL sat_cnt[%0d]: got done=%b err=%b cnt=%0d, want 1 1 %0d", i, done2, err2, err_cnt2, exp);
      end
    end
    cw_valid2 = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_during_scan();
    test_back_to_back();
    test_reset_mid_scan();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
